// File: rtl/ahb_dma_pkg.sv
// Shared definitions for the AHB frame DMA: HTRANS encodings, FSM state
// encoding and the transfer-size helper.
// Optional feature macro: AHB_DMA_ERR_ABORT_EN (adds the ERR state).
package ahb_dma_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
`ifdef AHB_DMA_ERR_ABORT_EN
        ST_DONE,
        ST_ERR
`else
        ST_DONE
`endif
    } dma_state_t;

    // HSIZE encoding is log2 of the bus width in bytes.
    function automatic logic [2:0] hsize_for(input int data_w);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == (data_w / 8)) r = i[2:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/ahb_dma_fifo.sv
// Read-return FIFO: buffers hrdata words until the fetched-word stream
// accepts them. Push is ignored when full, pop is ignored when empty.
module ahb_dma_fifo
    import ahb_dma_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy tracking; simultaneous push and pop keep count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage array; contents need no reset since empty gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ahb_frame_dma.sv
// AHB-Lite frame DMA master: reads width*height words from cfg_raddr into a
// return FIFO and writes the same number of result words to cfg_waddr,
// interleaving single NONSEQ beats round-robin.
// Optional feature macro: AHB_DMA_ERR_ABORT_EN (abort frame on HRESP error).
module ahb_frame_dma
    import ahb_dma_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DIM_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_raddr,
    input  logic [ADDR_W-1:0] cfg_waddr,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam int TOT_W = 2 * DIM_W;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

    dma_state_t        state;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [TOT_W-1:0]  total;
    logic [TOT_W-1:0]  rd_rem;
    logic [TOT_W-1:0]  wr_rem;
    logic [TOT_W-1:0]  rd_left;
    logic [TOT_W-1:0]  wr_left;
    logic [CNT_W-1:0]  rd_out;
    logic [DATA_W-1:0] wdat_p0;
    logic              rr_rd_pref;
    logic              dph_vld_p1;
    logic              dph_wr_p1;
    logic              rd_room;
    logic              rd_elig;
    logic              wr_elig;
    logic              issue_rd;
    logic              issue_wr;
    logic              launch;
    logic              err_hit;
    logic              fifo_flush;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign hsize = hsize_for(DATA_W);
    assign total = TOT_W'(cfg_width) * TOT_W'(cfg_height);

`ifdef AHB_DMA_ERR_ABORT_EN
    assign launch     = start && (state == ST_IDLE || state == ST_ERR);
    assign err_hit    = dph_vld_p1 && hresp && (state == ST_RUN || state == ST_FLUSH);
    assign fifo_flush = start && (state == ST_ERR);
`else
    logic unused_hresp;
    assign unused_hresp = hresp;
    assign launch       = start && (state == ST_IDLE);
    assign err_hit      = 1'b0;
    assign fifo_flush   = 1'b0;
    assign error        = 1'b0;
`endif

    // Reads in flight plus buffered words may never exceed the FIFO, so every
    // returning beat is guaranteed a slot.
    assign rd_room  = (({1'b0, fifo_count} + {1'b0, rd_out}) < SUM_W'(FIFO_DEPTH)) && !fifo_full;
    assign rd_elig  = (state == ST_RUN) && (rd_rem != '0) && rd_room;
    assign wr_elig  = (state == ST_RUN) && (wr_rem != '0) && wr_valid;
    assign issue_rd = rd_elig && (!wr_elig || rr_rd_pref);
    assign issue_wr = wr_elig && !issue_rd;
    assign rd_left  = rd_rem - TOT_W'(issue_rd);
    assign wr_left  = wr_rem - TOT_W'(issue_wr);

    assign fifo_push = hready && dph_vld_p1 && !dph_wr_p1 && !err_hit;
    assign fifo_pop  = rd_valid && rd_ready;
    assign rd_valid  = !fifo_empty;

    ahb_dma_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (hrdata),
        .pop       (fifo_pop),
        .pop_data  (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Frame FSM, AHB address/data phase sequencing and all registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            haddr      <= '0;
            htrans     <= HTRANS_IDLE;
            hwrite     <= 1'b0;
            hwdata     <= '0;
            wdat_p0    <= '0;
            rd_addr    <= '0;
            wr_addr    <= '0;
            rd_rem     <= '0;
            wr_rem     <= '0;
            rd_out     <= '0;
            rr_rd_pref <= 1'b1;
            dph_vld_p1 <= 1'b0;
            dph_wr_p1  <= 1'b0;
            wr_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef AHB_DMA_ERR_ABORT_EN
            error      <= 1'b0;
`endif
        end else begin
            wr_ready <= 1'b0;
            // done is registered off the DONE state, so it trails it by a cycle.
            done     <= (state == ST_DONE);
            // wr_ready pulses during the write address phase; the source holds
            // wr_valid/wr_data until then, so capture the word here.
            if (wr_ready) wdat_p0 <= wr_data;

            case ({hready && issue_rd, fifo_push})
                2'b10:   rd_out <= rd_out + 1'b1;
                2'b01:   rd_out <= rd_out - 1'b1;
                default: ;
            endcase

            if (hready) begin
                dph_vld_p1 <= (htrans == HTRANS_NONSEQ);
                dph_wr_p1  <= hwrite;
                if (htrans == HTRANS_NONSEQ && hwrite) hwdata <= wr_ready ? wr_data : wdat_p0;
                htrans <= HTRANS_IDLE;
                if (issue_rd) begin
                    htrans     <= HTRANS_NONSEQ;
                    hwrite     <= 1'b0;
                    haddr      <= rd_addr;
                    rd_addr    <= rd_addr + STEP;
                    rd_rem     <= rd_left;
                    rr_rd_pref <= 1'b0;
                end else if (issue_wr) begin
                    htrans     <= HTRANS_NONSEQ;
                    hwrite     <= 1'b1;
                    haddr      <= wr_addr;
                    wr_addr    <= wr_addr + STEP;
                    wr_rem     <= wr_left;
                    wr_ready   <= 1'b1;
                    rr_rd_pref <= 1'b1;
                end
            end

            if (launch) begin
                rd_addr    <= cfg_raddr;
                wr_addr    <= cfg_waddr;
                rd_rem     <= total;
                wr_rem     <= total;
                rr_rd_pref <= 1'b1;
                state      <= (total != '0) ? ST_RUN : ST_DONE;
                busy       <= (total != '0);
`ifdef AHB_DMA_ERR_ABORT_EN
                error      <= 1'b0;
                rd_out     <= '0;
`endif
            end else begin
                case (state)
                    ST_RUN:   if (hready && rd_left == '0 && wr_left == '0) state <= ST_FLUSH;
                    // Once no address phase is pending, this edge retires the last data phase.
                    ST_FLUSH: if (hready && htrans == HTRANS_IDLE) begin
                                  state <= ST_DONE;
                                  busy  <= 1'b0;
                              end
                    ST_DONE:  state <= ST_IDLE;
                    default:  ;
                endcase
            end

`ifdef AHB_DMA_ERR_ABORT_EN
            if (err_hit) begin
                state      <= ST_ERR;
                htrans     <= HTRANS_IDLE;
                busy       <= 1'b0;
                error      <= 1'b1;
                dph_vld_p1 <= 1'b0;
                wr_ready   <= 1'b0;
                rd_out     <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ahb_frame_dma.sv
// Directed self-checking bench for ahb_frame_dma with a zero-wait AHB slave
// model whose read data is the beat address XOR a fixed key.
module tb_ahb_frame_dma;

    localparam logic [31:0] RD_KEY = 32'h5A5A_0000;

    logic        clk;
    logic        n_rst;
    logic        start;
    logic [31:0] cfg_raddr;
    logic [31:0] cfg_waddr;
    logic [15:0] cfg_width;
    logic [15:0] cfg_height;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [31:0] addr_q[$];
    bit          dir_q[$];
    logic [31:0] wdat_q[$];
    logic [31:0] rd_q[$];

    logic        dp_vld;
    logic        dp_wr;
    logic [31:0] dp_addr;

    ahb_frame_dma #(
        .DATA_W     (32),
        .ADDR_W     (32),
        .DIM_W      (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .cfg_raddr  (cfg_raddr),
        .cfg_waddr  (cfg_waddr),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .haddr      (haddr),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hsize      (hsize),
        .hwdata     (hwdata),
        .hrdata     (hrdata),
        .hready     (hready),
        .hresp      (hresp),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign hrdata = dp_addr ^ RD_KEY;

    // Slave model: logs accepted address phases and completed write data.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_vld  <= 1'b0;
            dp_wr   <= 1'b0;
            dp_addr <= '0;
        end else if (hready) begin
            if (dp_vld && dp_wr) wdat_q.push_back(hwdata);
            if (htrans == 2'b10) begin
                addr_q.push_back(haddr);
                dir_q.push_back(hwrite);
                dp_addr <= haddr;
            end
            dp_vld <= (htrans == 2'b10);
            dp_wr  <= hwrite;
        end
    end

    // Fetched-word sink log and done pulse counter.
    always @(negedge clk) begin
        if (rd_valid && rd_ready) rd_q.push_back(rd_data);
        if (done) done_cnt++;
    end

    // Result-word source: advance the word after each accepted handshake.
    initial begin
        wr_data = 32'hD000_0000;
        forever begin
            @(negedge clk);
            if (wr_ready) begin
                @(posedge clk);
                #1;
                wr_data = wr_data + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        addr_q.delete();
        dir_q.delete();
        wdat_q.delete();
        rd_q.delete();
    endtask

    task automatic pulse_start(input logic [31:0] ra, input logic [31:0] wa,
                               input logic [15:0] w, input logic [15:0] h);
        @(negedge clk);
        cfg_raddr  = ra;
        cfg_waddr  = wa;
        cfg_width  = w;
        cfg_height = h;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Waits for done, counting negedges from the start cycle; optionally
    // stalls hready for 3 cycles at a given cycle and checks the hold.
    task automatic wait_done(input string tag, input int stall_at, input int budget, output int cyc);
        bit          seen;
        int          stall_left;
        logic [31:0] hold_a;
        seen       = 1'b0;
        stall_left = 0;
        hold_a     = '0;
        cyc        = 1;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (stall_left > 0) begin
                check({tag, "_hold_addr"}, haddr, hold_a);
                check({tag, "_hold_trans"}, htrans, 2'b10);
                stall_left--;
                if (stall_left == 0) hready = 1'b1;
            end else if (stall_at > 0 && cyc == stall_at) begin
                hold_a = haddr;
                check({tag, "_stall_addr"}, haddr, cfg_waddr);
                check({tag, "_stall_trans"}, htrans, 2'b10);
                hready     = 1'b0;
                stall_left = 3;
            end
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, seen, 1'b1);
    endtask

    initial begin
        int          cyc;
        int          base_cyc;
        int          dc;
        int          nrd;
        logic [31:0] wbase;
        logic [31:0] exp_a [8];
        logic [31:0] ra [$];

        n_rst      = 1'b0;
        start      = 1'b0;
        cfg_raddr  = '0;
        cfg_waddr  = '0;
        cfg_width  = '0;
        cfg_height = '0;
        hready     = 1'b1;
        hresp      = 1'b0;
        rd_ready   = 1'b1;
        wr_valid   = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_htrans", htrans, 2'b00);
        check("rst_haddr", haddr, 32'h0);
        check("rst_hwrite", hwrite, 1'b0);
        check("rst_hwdata", hwdata, 32'h0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("hsize", hsize, 3'd2);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // 2x2 frame, zero-wait slave: interleaved reads and writes
        clear_logs();
        dc    = done_cnt;
        wbase = wr_data;
        pulse_start(32'h1000, 32'h2000, 16'd2, 16'd2);
        check("f030_busy", busy, 1'b1);
        wait_done("f030", 0, 200, cyc);
        check("f030_cycles", cyc, 12);
        exp_a = '{32'h1000, 32'h2000, 32'h1004, 32'h2004, 32'h1008, 32'h2008, 32'h100C, 32'h200C};
        check("f030_nbeats", addr_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("f030_addr%0d", i), (i < addr_q.size()) ? addr_q[i] : 32'hDEAD_BEEF, exp_a[i]);
            check($sformatf("f030_dir%0d", i), (i < dir_q.size()) ? dir_q[i] : 1'bx, (i % 2));
        end
        repeat (3) @(negedge clk);
        check("f030_done_pulses", done_cnt - dc, 1);
        check("f030_busy_end", busy, 1'b0);
        check("f030_nrd", rd_q.size(), 4);
        check("f030_nwr", wdat_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("f030_rdata%0d", i), (i < rd_q.size()) ? rd_q[i] : 32'hDEAD_BEEF,
                  (32'h1000 + 32'(i * 4)) ^ RD_KEY);
            check($sformatf("f030_wdata%0d", i), (i < wdat_q.size()) ? wdat_q[i] : 32'hDEAD_BEEF,
                  wbase + 32'(i));
        end

        // Empty frame: no beats, done two cycles after start
        clear_logs();
        pulse_start(32'h1000, 32'h2000, 16'd0, 16'd5);
        check("f031_done_early", done, 1'b0);
        check("f031_busy", busy, 1'b0);
        wait_done("f031", 0, 20, cyc);
        check("f031_cycles", cyc, 2);
        @(negedge clk);
        check("f031_done_single", done, 1'b0);
        check("f031_nbeats", addr_q.size(), 0);

        // Back-pressured read stream: FIFO bounds the reads in flight
        clear_logs();
        rd_ready = 1'b0;
        pulse_start(32'h3000, 32'h4000, 16'd8, 16'd1);
        repeat (40) @(negedge clk);
        nrd = 0;
        foreach (dir_q[i]) if (!dir_q[i]) nrd++;
        check("f032_reads_stalled", nrd, 4);
        check("f032_rd_valid", rd_valid, 1'b1);
        check("f032_busy", busy, 1'b1);
        rd_ready = 1'b1;
        wait_done("f032", 0, 200, cyc);
        repeat (3) @(negedge clk);
        nrd = 0;
        foreach (dir_q[i]) if (!dir_q[i]) nrd++;
        check("f032_reads_total", nrd, 8);
        check("f032_nrd", rd_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("f032_rdata%0d", i), (i < rd_q.size()) ? rd_q[i] : 32'hDEAD_BEEF,
                  (32'h3000 + 32'(i * 4)) ^ RD_KEY);
        end

        // Wait states on the 2nd beat add exactly 3 cycles
        clear_logs();
        pulse_start(32'h1000, 32'h2000, 16'd2, 16'd1);
        wait_done("f033a", 0, 200, base_cyc);
        check("f033_base_cycles", base_cyc, 8);
        repeat (2) @(negedge clk);
        pulse_start(32'h1000, 32'h2000, 16'd2, 16'd1);
        wait_done("f033b", 3, 200, cyc);
        check("f033_extra_cycles", cyc - base_cyc, 3);

        // Source address wraps at the top of the address space
        repeat (2) @(negedge clk);
        clear_logs();
        pulse_start(32'hFFFF_FFFC, 32'h5000, 16'd2, 16'd1);
        wait_done("f034", 0, 200, cyc);
        foreach (dir_q[i]) if (!dir_q[i]) ra.push_back(addr_q[i]);
        check("f034_nreads", ra.size(), 2);
        check("f034_raddr0", (ra.size() > 0) ? ra[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("f034_raddr1", (ra.size() > 1) ? ra[1] : 32'hDEAD_BEEF, 32'h0000_0000);

        // Reset mid-frame abandons the transfer
        repeat (2) @(negedge clk);
        pulse_start(32'h1000, 32'h2000, 16'd4, 16'd4);
        repeat (5) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("f026_htrans", htrans, 2'b00);
        check("f026_busy", busy, 1'b0);
        check("f026_rd_valid", rd_valid, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        clear_logs();
        dc = done_cnt;
        repeat (20) @(negedge clk);
        check("f026_no_beats", addr_q.size(), 0);
        check("f026_no_done", done_cnt - dc, 0);

`ifdef AHB_DMA_ERR_ABORT_EN
        // Error response on the 3rd beat aborts the frame
        dc = done_cnt;
        pulse_start(32'h1000, 32'h2000, 16'd4, 16'd1);
        repeat (3) @(negedge clk);
        check("f035_beat3_addr", haddr, 32'h1004);
        check("f035_beat3_trans", htrans, 2'b10);
        @(negedge clk);
        hresp = 1'b1;
        @(negedge clk);
        hresp = 1'b0;
        check("f035_error", error, 1'b1);
        check("f035_htrans", htrans, 2'b00);
        check("f035_busy", busy, 1'b0);
        clear_logs();
        repeat (20) @(negedge clk);
        check("f035_no_beats", addr_q.size(), 0);
        check("f035_no_done", done_cnt - dc, 0);
        check("f035_error_held", error, 1'b1);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("f035_error_cleared", error, 1'b0);
`else
        // Without the abort feature hresp has no effect
        hresp = 1'b1;
        pulse_start(32'h1000, 32'h2000, 16'd2, 16'd1);
        wait_done("f035", 0, 200, cyc);
        check("f035_cycles", cyc, 8);
        check("f035_error", error, 1'b0);
        hresp = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_frame_dma.md
AHB_FRAME_DMA -- requirements
Module: ahb_frame_dma

Interface
REQ-001 Parameter DATA_W, default 32, AHB data and pixel-word width (32 or 64).
REQ-002 Parameter ADDR_W, default 32, AHB address width.
REQ-003 Parameter DIM_W, default 16, width of each frame-dimension field.
REQ-004 Parameter FIFO_DEPTH, default 4, read-return FIFO entries (power of 2, >=2).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 n_rst  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle pulse that launches a frame.
REQ-008 cfg_raddr / cfg_waddr  in  ADDR_W  source / destination base byte address.
REQ-009 cfg_width / cfg_height  in  DIM_W  frame dimensions in words.
REQ-010 haddr  out  ADDR_W; htrans  out  2; hwrite  out  1; hsize  out  3; hwdata  out  DATA_W: AHB-Lite master request.
REQ-011 hrdata  in  DATA_W; hready  in  1; hresp  in  1: AHB-Lite master response.
REQ-012 rd_data  out  DATA_W; rd_valid  out  1; rd_ready  in  1: fetched-word stream.
REQ-013 wr_data  in  DATA_W; wr_valid  in  1; wr_ready  out  1: result-word stream.
REQ-014 busy, done, error  out  1 each: status outputs.

Function
REQ-015 FSM states SHALL be IDLE, RUN, FLUSH, DONE, ERR.
- IDLE->RUN on start when width*height != 0.
- IDLE->DONE on start when width*height == 0.
- RUN->FLUSH when both remaining counts reach 0.
- FLUSH->DONE once the last data phase completes with hready=1.
- DONE->IDLE after one cycle.
REQ-016 On start, the block SHALL latch both base addresses and total = width*height (2*DIM_W bits) as read_remaining and write_remaining; start outside IDLE SHALL be ignored.
REQ-017 Transfers SHALL be single NONSEQ beats; htrans=IDLE(00) when no beat is issued; hsize=log2(DATA_W/8).
REQ-018 A read address phase SHALL be issued only if read_remaining>0 and FIFO occupancy plus outstanding reads < FIFO_DEPTH.
REQ-019 A write address phase SHALL be issued only if write_remaining>0 and wr_valid=1; wr_ready SHALL pulse in that same cycle; wr_data SHALL drive hwdata in the following data phase.
REQ-020 When both read and write are eligible, the block SHALL alternate round-robin, starting with read after start.
REQ-021 The address phase SHALL hold while hready=0; counters, addresses and arbitration SHALL advance only on hready=1.
REQ-022 Each accepted beat SHALL advance its address by DATA_W/8 modulo 2^ADDR_W and decrement its remaining count.
REQ-023 hrdata SHALL be pushed into the FIFO in the read data phase when hready=1.
- rd_valid = FIFO not empty; a pop occurs on rd_valid && rd_ready.
- Push and pop in the same cycle SHALL leave occupancy unchanged.
- Overflow SHALL be impossible by REQ-018.
REQ-024 busy=1 in RUN and FLUSH; done SHALL be a single-cycle pulse in DONE.

Reset
REQ-025 n_rst=0 SHALL immediately force IDLE, htrans=00, haddr=0, hwrite=0, hwdata=0, counters 0, FIFO empty, rd_valid=0, wr_ready=0, busy=0, done=0, error=0.
REQ-026 Reset mid-frame SHALL abandon the frame; no beat completes after reset release until a new start.

Configuration
REQ-027 With macro AHB_DMA_ERR_ABORT_EN defined:
- hresp=1 in any data phase SHALL drive htrans=00 in the next cycle, move the FSM to ERR and set error=1.
- ERR holds until the next start, which clears error and flushes the FIFO.
- Without the macro, hresp SHALL be ignored, error tied 0 and the ERR state not built.

Structure
REQ-028 Package ahb_dma_pkg SHALL hold the HTRANS encodings (IDLE=2'b00, NONSEQ=2'b10), the FSM state enum and the hsize computation function.
REQ-029 Read-return buffering SHALL be a sub-module ahb_dma_fifo (parameters DATA_W, FIFO_DEPTH) with push, pop, full, empty and count outputs.

Verification
REQ-030 width=2, height=2, raddr=0x1000, waddr=0x2000, zero-wait slave, rd_ready=1, wr_valid=1 -> addresses interleave 0x1000, 0x2000, 0x1004, 0x2004, ...; 4 reads and 4 writes; one done pulse.
REQ-031 width=0, height=5 -> no htrans NONSEQ; done pulses 2 cycles after start.
REQ-032 rd_ready=0, 8-word frame, FIFO_DEPTH=4 -> exactly 4 reads issued, then stall; resume on rd_ready=1; data order preserved.
REQ-033 hready=0 for 3 cycles on the 2nd beat -> haddr and htrans held stable; total cycle count increases by 3.
REQ-034 raddr=0xFFFF_FFFC, 2-word frame -> second read at 0x0000_0000.
REQ-035 With AHB_DMA_ERR_ABORT_EN, hresp=1 on 3rd beat -> error=1, no further NONSEQ, no done; n_rst pulse clears error.
